// File: rtl/lvt_multiport_table.sv
// Live Value Table: tracks which write port last wrote each index, with a sequential clear sweep.
// Optional macro LVT_BYPASS_EN selects write-first read behaviour (default build is read-first).
module lvt_multiport_table #(
    parameter int W_PORTS     = 4,
    parameter int R_PORTS     = 4,
    parameter int INDEX_WIDTH = 8,
    parameter int SEL_WIDTH   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           clr,
    input  logic [W_PORTS*INDEX_WIDTH-1:0] w_addr,
    input  logic [W_PORTS-1:0]             w_en,
    input  logic [R_PORTS*INDEX_WIDTH-1:0] r_addr,
    input  logic [R_PORTS-1:0]             r_en,
    output logic [R_PORTS*SEL_WIDTH-1:0]   r_sel,
    output logic [R_PORTS-1:0]             r_valid,
    output logic                           ready,
    output logic                           conflict
);

    localparam int DEPTH = 2 ** INDEX_WIDTH;
    localparam logic [INDEX_WIDTH:0] LAST = (INDEX_WIDTH + 1)'(DEPTH - 1);

    typedef enum logic {INIT, RUN} state_t;

    state_t                     state;
    logic [INDEX_WIDTH:0]       cnt;
    logic [SEL_WIDTH-1:0]       entry [DEPTH];
    logic                       wr_hit;
    logic [R_PORTS*SEL_WIDTH-1:0] rd_data;

    // Any pair of enabled write ports landing on the same index.
    always_comb begin
        wr_hit = 1'b0;
        for (int i = 0; i < W_PORTS; i++) begin
            for (int k = i + 1; k < W_PORTS; k++) begin
                if (w_en[i] && w_en[k] &&
                    w_addr[i*INDEX_WIDTH +: INDEX_WIDTH] == w_addr[k*INDEX_WIDTH +: INDEX_WIDTH])
                    wr_hit = 1'b1;
            end
        end
    end

    always_comb begin
        rd_data = '0;
        for (int j = 0; j < R_PORTS; j++) begin
            rd_data[j*SEL_WIDTH +: SEL_WIDTH] = entry[r_addr[j*INDEX_WIDTH +: INDEX_WIDTH]];
`ifdef LVT_BYPASS_EN
            // Ascending scan so the highest matching write port overrides, as in the table.
            for (int i = 0; i < W_PORTS; i++) begin
                if (w_en[i] &&
                    w_addr[i*INDEX_WIDTH +: INDEX_WIDTH] == r_addr[j*INDEX_WIDTH +: INDEX_WIDTH])
                    rd_data[j*SEL_WIDTH +: SEL_WIDTH] = SEL_WIDTH'(i);
            end
`endif
        end
    end

    // Table storage: cleared by the sweep, otherwise last writer wins by port index.
    always_ff @(posedge clk) begin
        if (reset) begin
            if (state == INIT) begin
                entry[cnt[INDEX_WIDTH-1:0]] <= '0;
            end else begin
                for (int i = 0; i < W_PORTS; i++) begin
                    if (w_en[i])
                        entry[w_addr[i*INDEX_WIDTH +: INDEX_WIDTH]] <= SEL_WIDTH'(i);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= INIT;
            cnt      <= '0;
            ready    <= 1'b0;
            r_sel    <= '0;
            r_valid  <= '0;
            conflict <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    r_valid  <= '0;
                    conflict <= 1'b0;
                    if (clr) begin
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else if (cnt == LAST) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end else begin
                        cnt   <= cnt + (INDEX_WIDTH + 1)'(1);
                        ready <= 1'b0;
                    end
                end
                RUN: begin
                    conflict <= wr_hit;
                    r_valid  <= r_en;
                    for (int j = 0; j < R_PORTS; j++) begin
                        if (r_en[j])
                            r_sel[j*SEL_WIDTH +: SEL_WIDTH] <= rd_data[j*SEL_WIDTH +: SEL_WIDTH];
                    end
                    if (clr) begin
                        state <= INIT;
                        cnt   <= '0;
                        ready <= 1'b0;
                    end else begin
                        ready <= 1'b1;
                    end
                end
                default: state <= INIT;
            endcase
        end
    end

endmodule
